uart_receiver: RTL and testbench

- Receive side of the UART link. Pairs with uart_transmitter, using the same frame format and baud_select encoding.
- Samples the serial line RxD at 16x the bit rate, recovers one 8-bit byte per frame and checks even parity and the stop bit.
- Outputs a one-clock data-valid or error strobe toward the downstream logic.

---
 rtl/uart_receiver.sv | 170 +++++++++++++++++
 tb/tb_uart_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling UART receive side, 8E1 frames.
// Ports: clock/reset, baud_select, Rx_EN, RxD in; Rx_DATA and
//   Rx_VALID/Rx_PERROR/Rx_FERROR strobes, Rx_BUSY out.
module uart_receiver #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Rounded divisor; clamped to 1 so very slow clocks still tick.
  function automatic logic [13:0] div_of(input logic [2:0] sel);
    int baud;
    int d;
    baud = 300;
    unique case (sel)
      3'd0: baud = 300;
      3'd1: baud = 1200;
      3'd2: baud = 4800;
      3'd3: baud = 9600;
      3'd4: baud = 19200;
      3'd5: baud = 38400;
      3'd6: baud = 57600;
      3'd7: baud = 115200;
    endcase
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d[13:0];
  endfunction

  state_t      state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [2:0]  baud_q;
  logic [13:0] tick_cnt;
  logic [3:0]  sub;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [13:0] div_m1;
  logic        tick;
  logic        fall;

  assign div_m1 = div_of(baud_q) - 14'd1;
  assign tick   = Rx_EN && (tick_cnt == div_m1);
  assign fall   = rx_prev & ~rx_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_q    <= 3'd0;
      tick_cnt  <= 14'd0;
      sub       <= 4'd0;
      idx       <= 3'd0;
      shreg     <= 8'd0;
      par_bit   <= 1'b0;
      Rx_DATA   <= 8'd0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_BUSY   <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (!Rx_EN || tick) tick_cnt <= 14'd0;
      else tick_cnt <= tick_cnt + 14'd1;
      if (!Rx_EN) begin
        state   <= IDLE;
        Rx_BUSY <= 1'b0;
        sub     <= 4'd0;
        idx     <= 3'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fall) begin
              state    <= START;
              Rx_BUSY  <= 1'b1;
              baud_q   <= baud_select;
              tick_cnt <= 14'd0;
              sub      <= 4'd0;
              idx      <= 3'd0;
            end
          end
          START: begin
            if (tick) begin
              sub <= sub + 4'd1;
              // Mid start bit: realign so later samples hit bit centres.
              if (sub == 4'd7) begin
                sub <= 4'd0;
                if (rx_s2) begin
                  state   <= IDLE;
                  Rx_BUSY <= 1'b0;
                end else begin
                  state <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (tick) begin
              sub <= sub + 4'd1;
              if (sub == 4'd15) begin
                shreg[idx] <= rx_s2;
                idx        <= idx + 3'd1;
                if (idx == 3'd7) state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              sub <= sub + 4'd1;
              if (sub == 4'd15) begin
                par_bit <= rx_s2;
                state   <= STOP;
              end
            end
          end
          STOP: begin
            if (tick) begin
              sub <= sub + 4'd1;
              if (sub == 4'd15) begin
                state   <= IDLE;
                Rx_BUSY <= 1'b0;
                Rx_DATA <= shreg;
                if (!rx_s2) Rx_FERROR <= 1'b1;
                else if ((^shreg) != par_bit) Rx_PERROR <= 1'b1;
                else Rx_VALID <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            Rx_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random + directed frames, queue scoreboard.
// Reduced CLK_HZ keeps the 300 baud case short.
module tb_uart_receiver;

  localparam int CLK_HZ = 600000;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_BUSY;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data;
  int         bauds[8] = '{300, 1200, 4800, 9600,
                           19200, 38400, 57600, 115200};

  uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
    .clock(clock),
    .reset(reset),
    .baud_select(baud_select),
    .Rx_EN(Rx_EN),
    .RxD(RxD),
    .Rx_DATA(Rx_DATA),
    .Rx_VALID(Rx_VALID),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR),
    .Rx_BUSY(Rx_BUSY)
  );

  always #10 clock = ~clock;

  function automatic int div_of(input int sel);
    int d;
    d = (CLK_HZ + 8 * bauds[sel]) / (16 * bauds[sel]);
    if (d < 1) d = 1;
    return d;
  endfunction

  task automatic check(input string name, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b, input int n);
    RxD = b;
    wait_clks(n);
  endtask

  // Reference: stop error wins, then parity, else good byte.
  task automatic expect_frame(input logic [7:0] d, input logic p,
                              input logic s);
    exp_t e;
    e.data = d;
    if (!s) e.kind = 3'b001;
    else if (p != (^d)) e.kind = 3'b010;
    else e.kind = 3'b100;
    q.push_back(e);
    last_data = d;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input int n,
                            input bit scramble);
    logic [2:0] sel0;
    sel0 = baud_select;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      if (scramble && i == 1) baud_select = 3'($urandom);
      if (i == 4) begin
        RxD = d[i];
        wait_clks(n / 2);
        check("busy_mid_frame", Rx_BUSY, 1);
        wait_clks(n - n / 2);
      end else begin
        drive_bit(d[i], n);
      end
    end
    baud_select = sel0;
    drive_bit(p, n);
    drive_bit(s, n);
  endtask

  task automatic partial_frame(input logic [7:0] d, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 4; i++) drive_bit(d[i], n);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && (Rx_VALID || Rx_PERROR || Rx_FERROR)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got v%0b p%0b f%0b data %0h expected none",
                 Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
      end else begin
        e = q.pop_front();
        check("strobe_kind", {Rx_VALID, Rx_PERROR, Rx_FERROR},
              e.kind);
        check("strobe_data", Rx_DATA, e.data);
      end
    end
  end

  initial begin
    int n;
    int dv;
    logic [7:0] d;
    logic p;
    logic s;
    reset = 1'b1;
    Rx_EN = 1'b1;
    baud_select = 3'd7;
    RxD = 1'b1;
    last_data = 8'd0;
    wait_clks(3);
    check("reset_data", Rx_DATA, 0);
    check("reset_valid", Rx_VALID, 0);
    check("reset_perror", Rx_PERROR, 0);
    check("reset_ferror", Rx_FERROR, 0);
    check("reset_busy", Rx_BUSY, 0);
    reset = 1'b0;
    wait_clks(5);

    dv = div_of(7);
    n = 16 * dv;
    expect_frame(8'hA8, 1'b1, 1'b1);
    send_frame(8'hA8, 1'b1, 1'b1, n, 0);
    drive_bit(1'b1, n);
    expect_frame(8'h88, 1'b1, 1'b1);
    send_frame(8'h88, 1'b1, 1'b1, n, 0);
    drive_bit(1'b1, n);
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, n, 0);
    wait_clks(3 * n);
    check("no_retrigger_low", Rx_BUSY, 0);
    drive_bit(1'b1, 2 * n);
    expect_frame(8'h0F, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1, n, 0);
    drive_bit(1'b1, n);

    drive_bit(1'b0, 4 * dv);
    drive_bit(1'b1, 4 * dv + 4);
    check("glitch_busy", Rx_BUSY, 0);
    wait_clks(n);
    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, n, 0);
    drive_bit(1'b1, n);

    partial_frame(8'h5A, n);
    Rx_EN = 1'b0;
    RxD = 1'b1;
    wait_clks(5);
    Rx_EN = 1'b1;
    wait_clks(1);
    check("en_abort_busy", Rx_BUSY, 0);
    wait_clks(2 * n);
    check("en_abort_data", Rx_DATA, last_data);
    expect_frame(8'hC3, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, n, 0);
    drive_bit(1'b1, n);

    partial_frame(8'hA5, n);
    reset = 1'b1;
    RxD = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    last_data = 8'd0;
    wait_clks(1);
    check("rst_abort_data", Rx_DATA, 0);
    check("rst_abort_busy", Rx_BUSY, 0);
    check("rst_abort_strobes", {Rx_VALID, Rx_PERROR, Rx_FERROR}, 0);
    wait_clks(2 * n);
    expect_frame(8'hC3, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, n, 0);
    drive_bit(1'b1, n);

    for (int k = 0; k < 20; k++) begin
      baud_select = 3'($urandom_range(4, 7));
      n = 16 * div_of(int'(baud_select));
      drive_bit(1'b1, n * (1 + $urandom_range(0, 2)));
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(0, 3) != 0);
      expect_frame(d, p, s);
      send_frame(d, p, s, n, 1);
    end
    drive_bit(1'b1, n);

    baud_select = 3'd0;
    n = 16 * div_of(0);
    drive_bit(1'b1, n);
    expect_frame(8'hF0, 1'b0, 1'b1);
    expect_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1, n, 0);
    send_frame(8'h01, 1'b1, 1'b1, n, 0);
    drive_bit(1'b1, 4);

    for (int i = 0; i < 4 * n && q.size() != 0; i++)
      @(negedge clock);
    check("queue_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
